// File: rtl/display_packet_builder.sv
// display_packet_builder: merges image, bbox and logo sources into framed 64-bit packets
// (header word with type in [2:0], fixed-length payload, out_last on the final payload word).
// Optional logo source is compiled in with DISPLAY_PKT_LOGO_EN; without it logo_ready is 0
// and arbitration is bbox > image.
module display_packet_builder #(
   parameter int FRAME_WIDTH  = 540,
   parameter int FRAME_HEIGHT = 540,
   parameter int MAX_BBOX     = 16,
   parameter int LOGO_WIDTH   = 540,
   parameter int LOGO_HEIGHT  = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        img_valid,
   input  logic [63:0] img_data,
   output logic        img_ready,
   input  logic        bbox_valid,
   input  logic        bbox_last,
   input  logic [63:0] bbox_data,
   output logic        bbox_ready,
   input  logic        logo_valid,
   input  logic [63:0] logo_data,
   output logic        logo_ready,
   output logic        out_valid,
   output logic        out_last,
   output logic [63:0] out_data,
   input  logic        out_ready
);
   localparam logic [21:0] IMG_END  = 22'(FRAME_WIDTH * FRAME_HEIGHT / 2 - 1);
   localparam logic [21:0] LOGO_END = 22'(LOGO_WIDTH * LOGO_HEIGHT / 2 - 1);
   localparam logic [21:0] BBOX_END = 22'(MAX_BBOX - 1);
`ifdef DISPLAY_PKT_LOGO_EN
   typedef enum logic [2:0] {IDLE, IMG, BBOX, BPAD, BDROP, LOGO} state_t;
`else
   typedef enum logic [2:0] {IDLE, IMG, BBOX, BPAD, BDROP} state_t;
`endif
   state_t      state_q, state_d;
   logic [21:0] cnt_q, cnt_d;
   logic        out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [63:0] out_data_q, out_data_d;
   logic        adv, logo_sel, img_end, bbox_end;
   assign adv      = ~out_valid_q | out_ready;
   assign img_end  = cnt_q == IMG_END;
   assign bbox_end = cnt_q == BBOX_END;
`ifdef DISPLAY_PKT_LOGO_EN
   logic logo_end;
   assign logo_sel = logo_valid;
   assign logo_end = cnt_q == LOGO_END;
`else
   logic unused_logo;
   assign logo_sel    = 1'b0;
   assign unused_logo = ^{logo_valid, logo_data, LOGO_END};
`endif
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;
   // Next state, payload counter, output register load and source readies
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      img_ready   = 1'b0;
      bbox_ready  = 1'b0;
      logo_ready  = 1'b0;
      if (adv) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (adv && (bbox_valid || logo_sel || img_valid)) begin
               out_valid_d = 1'b1;
               out_data_d  = {61'd0, bbox_valid ? 3'd2 : logo_sel ? 3'd3 : 3'd1};
`ifdef DISPLAY_PKT_LOGO_EN
               state_d     = bbox_valid ? BBOX : logo_valid ? LOGO : IMG;
`else
               state_d     = bbox_valid ? BBOX : IMG;
`endif
            end
         end
         IMG: begin
            img_ready = adv;
            if (adv && img_valid) begin
               out_valid_d = 1'b1;
               out_data_d  = img_data;
               out_last_d  = img_end;
               cnt_d       = img_end ? '0 : cnt_q + 22'd1;
               state_d     = img_end ? IDLE : IMG;
            end
         end
`ifdef DISPLAY_PKT_LOGO_EN
         LOGO: begin
            logo_ready = adv;
            if (adv && logo_valid) begin
               out_valid_d = 1'b1;
               out_data_d  = logo_data;
               out_last_d  = logo_end;
               cnt_d       = logo_end ? '0 : cnt_q + 22'd1;
               state_d     = logo_end ? IDLE : LOGO;
            end
         end
`endif
         BBOX: begin
            bbox_ready = adv;
            if (adv && bbox_valid) begin
               out_valid_d = 1'b1;
               out_data_d  = bbox_data;
               out_last_d  = bbox_end;
               cnt_d       = bbox_end ? '0 : cnt_q + 22'd1;
               state_d     = bbox_end ? (bbox_last ? IDLE : BDROP) : (bbox_last ? BPAD : BBOX);
            end
         end
         BPAD: begin
            if (adv) begin
               out_valid_d = 1'b1;
               out_data_d  = 64'd0;
               out_last_d  = bbox_end;
               cnt_d       = bbox_end ? '0 : cnt_q + 22'd1;
               state_d     = bbox_end ? IDLE : BPAD;
            end
         end
         BDROP: begin
            bbox_ready = 1'b1;
            if (bbox_valid && bbox_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // State, counter and output register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end
endmodule

// File: tb/tb_display_packet_builder.sv
// tb_display_packet_builder: randomized packet-level scoreboard bench for display_packet_builder
module tb_display_packet_builder;
   localparam int FW = 4, FH = 2, MB = 4, LW = 4, LH = 3;
   localparam int IMG_CNT = FW * FH / 2, LOGO_CNT = LW * LH / 2;
`ifdef DISPLAY_PKT_LOGO_EN
   localparam bit LOGO_EN = 1'b1;
`else
   localparam bit LOGO_EN = 1'b0;
`endif
   logic        clk = 1'b0, rst;
   logic        img_valid, img_ready, bbox_valid, bbox_last, bbox_ready, logo_valid, logo_ready;
   logic [63:0] img_data, bbox_data, logo_data, out_data;
   logic        out_valid, out_last, out_ready;
   logic        b1_valid, b1_last, b1_ready, i1_ready, l1_ready, o1_valid, o1_last;
   logic [63:0] b1_data, o1_data;
   logic        zero1 = 1'b0, one1 = 1'b1;
   logic [63:0] zero64 = 64'd0;
   int          n_chk = 0, n_pass = 0, img_pops = 0;
   logic [64:0] exp_q[$], bbox_q[$];
   logic [63:0] img_q[$], logo_q[$];
   bit          gaps, rnd_rdy, prev_stall;
   logic [63:0] prev_data;
   logic        prev_last;

   display_packet_builder #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .MAX_BBOX(MB),
                            .LOGO_WIDTH(LW), .LOGO_HEIGHT(LH)) dut (
      .clk(clk), .rst(rst),
      .img_valid(img_valid), .img_data(img_data), .img_ready(img_ready),
      .bbox_valid(bbox_valid), .bbox_last(bbox_last), .bbox_data(bbox_data), .bbox_ready(bbox_ready),
      .logo_valid(logo_valid), .logo_data(logo_data), .logo_ready(logo_ready),
      .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .out_ready(out_ready));

   display_packet_builder #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .MAX_BBOX(1),
                            .LOGO_WIDTH(LW), .LOGO_HEIGHT(LH)) dut1 (
      .clk(clk), .rst(rst),
      .img_valid(zero1), .img_data(zero64), .img_ready(i1_ready),
      .bbox_valid(b1_valid), .bbox_last(b1_last), .bbox_data(b1_data), .bbox_ready(b1_ready),
      .logo_valid(zero1), .logo_data(zero64), .logo_ready(l1_ready),
      .out_valid(o1_valid), .out_last(o1_last), .out_data(o1_data), .out_ready(one1));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic add_img(input bit directed);
      logic [63:0] w;
      exp_q.push_back({1'b0, 64'd1});
      for (int i = 0; i < IMG_CNT; i++) begin
         w = directed ? 64'h11 * 64'(i + 1) : {$urandom, $urandom};
         img_q.push_back(w);
         exp_q.push_back({i == IMG_CNT - 1, w});
      end
   endtask

   task automatic add_logo();
      logic [63:0] w;
      if (LOGO_EN) exp_q.push_back({1'b0, 64'd3});
      for (int i = 0; i < LOGO_CNT; i++) begin
         w = {$urandom, $urandom};
         logo_q.push_back(w);
         if (LOGO_EN) exp_q.push_back({i == LOGO_CNT - 1, w});
      end
   endtask

   task automatic add_bbox(input int n);
      logic [63:0] w;
      exp_q.push_back({1'b0, 64'd2});
      for (int i = 0; i < n; i++) begin
         w = {$urandom, $urandom};
         bbox_q.push_back({i == n - 1, w});
         if (i < MB) exp_q.push_back({i == MB - 1, w});
      end
      for (int i = n; i < MB; i++) exp_q.push_back({i == MB - 1, 64'd0});
   endtask

   task automatic step();
      logic [64:0] w;
      img_valid  = img_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0);
      img_data   = img_q.size() != 0 ? img_q[0] : 64'd0;
      bbox_valid = bbox_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0);
      {bbox_last, bbox_data} = bbox_q.size() != 0 ? bbox_q[0] : 65'd0;
      logo_valid = logo_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0);
      logo_data  = logo_q.size() != 0 ? logo_q[0] : 64'd0;
      out_ready  = !rnd_rdy || $urandom_range(0, 2) != 0;
      #1;
      if (prev_stall) begin
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_data", out_data, prev_data);
         check("hold_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && !out_ready) begin
         check("stall_img_ready", 64'(img_ready), 64'd0);
         check("stall_logo_ready", 64'(logo_ready), 64'd0);
      end
      if (!LOGO_EN && logo_valid) check("logo_ready_off", 64'(logo_ready), 64'd0);
      if (img_valid && img_ready) begin void'(img_q.pop_front()); img_pops++; end
      if (bbox_valid && bbox_ready) void'(bbox_q.pop_front());
      if (logo_valid && logo_ready) void'(logo_q.pop_front());
      if (out_valid && out_ready) begin
         check("word_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("out_data", out_data, w[63:0]);
            check("out_last", 64'(out_last), 64'(w[64]));
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      @(negedge clk);
   endtask

   task automatic run(output int n);
      n = 0;
      while ((exp_q.size() != 0 || img_q.size() != 0 || bbox_q.size() != 0 ||
              (LOGO_EN && logo_q.size() != 0)) && n < 400) begin
         step();
         n++;
      end
      check("drain_in_budget", 64'(n < 400), 64'd1);
      repeat (4) step();
      exp_q.delete(); img_q.delete(); bbox_q.delete(); logo_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_img_ready", 64'(img_ready), 64'd0);
      check("rst_bbox_ready", 64'(bbox_ready), 64'd0);
      check("rst_logo_ready", 64'(logo_ready), 64'd0);
      exp_q.delete(); img_q.delete(); bbox_q.delete(); logo_q.delete();
      prev_stall = 1'b0;
      img_valid = 1'b0; bbox_valid = 1'b0; logo_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int n, kind;
      logic [63:0] r;
      rst = 1'b1; out_ready = 1'b1; gaps = 0; rnd_rdy = 0; prev_stall = 0;
      img_valid = 0; bbox_valid = 0; logo_valid = 0; bbox_last = 0;
      img_data = '0; bbox_data = '0; logo_data = '0;
      b1_valid = 0; b1_last = 0; b1_data = '0;
      repeat (2) @(negedge clk);
      do_reset();
      add_img(1'b1);
      run(n);
      check("img_b2b_cycles", 64'(n), 64'd6);
      add_bbox(2);
      run(n);
      add_bbox(6);
      run(n);
      add_bbox(1); add_logo(); add_img(1'b0);
      run(n);
      r = {$urandom, $urandom};
      b1_valid = 1'b1; b1_last = 1'b1; b1_data = r;
      @(negedge clk);
      check("mb1_hdr_valid", 64'(o1_valid), 64'd1);
      check("mb1_hdr", o1_data, 64'd2);
      check("mb1_hdr_last", 64'(o1_last), 64'd0);
      check("mb1_ready", 64'(b1_ready), 64'd1);
      @(negedge clk);
      b1_valid = 1'b0;
      check("mb1_word", o1_data, r);
      check("mb1_word_last", 64'(o1_last), 64'd1);
      @(negedge clk);
      check("mb1_idle", 64'(o1_valid), 64'd0);
      check("mb1_img_ready", 64'(i1_ready | l1_ready), 64'd0);
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 3);
         gaps = kind != 3 && $urandom_range(0, 1) != 0;
         rnd_rdy = $urandom_range(0, 1) != 0;
         case (kind)
            0: add_img(1'b0);
            1: add_bbox($urandom_range(1, 7));
            2: add_logo();
            default: begin add_bbox($urandom_range(1, 7)); add_logo(); add_img(1'b0); end
         endcase
         run(n);
      end
      gaps = 0; rnd_rdy = 0; img_pops = 0;
      add_img(1'b0);
      n = 0;
      while (img_pops < 2 && n < 20) begin step(); n++; end
      check("pre_reset_pops", 64'(img_pops), 64'd2);
      img_valid = 1'b1;
      do_reset();
      add_img(1'b0);
      run(n);
      gaps = 1; rnd_rdy = 1;
      add_logo(); add_img(1'b0);
      run(n);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/display_packet_builder.md
Name: display_packet_builder

Overview:
- Upstream neighbour of the display annotation stage. Merges three sources into one framed 64-bit packet stream, with a header word, payload and last flag.
- Sources: camera image words (2 pixels per word), bounding-box records from the inference post-processor, and logo image words.
- Every output packet is one header word, whose [2:0] is the packet type, followed by a fixed-length payload. out_last marks the final payload word.
- The downstream annotator relies on these exact payload lengths.

Parameters:
FRAME_WIDTH, 540, image width in pixels (must be even)
FRAME_HEIGHT, 540, image height in lines
MAX_BBOX, 16, bbox payload length in words
LOGO_WIDTH, 540, logo width in pixels (must be even)
LOGO_HEIGHT, 100, logo height in lines

Ports:
clk  in  1  single clock; all logic in this domain
rst  in  1  synchronous, active-high reset
img_valid  in  1  image word valid
img_data  in  64  two RGB pixels
img_ready  out  1  image word accepted when img_valid & img_ready
bbox_valid  in  1  bbox record valid
bbox_last  in  1  final record of current inference result
bbox_data  in  64  one bbox record (opaque, passed through)
bbox_ready  out  1  bbox handshake ready
logo_valid  in  1  logo word valid
logo_data  in  64  two logo pixels
logo_ready  out  1  logo handshake ready
out_valid  out  1  output word valid
out_last  out  1  final word of packet
out_data  out  64  header or payload word
out_ready  in  1  downstream ready

Behaviour:
- Constants: IMG_CNT = FRAME_WIDTH*FRAME_HEIGHT/2; LOGO_CNT = LOGO_WIDTH*LOGO_HEIGHT/2.
- Packet types in header [2:0]:
  - 3'd1 image
  - 3'd2 bbox
  - 3'd3 logo
  - header [63:3] = 0.
- Output register:
  - out_valid, out_last and out_data are registered.
  - The register loads when (~out_valid | out_ready).
  - out_data/out_last stay stable while out_valid & ~out_ready.
  - Define adv = ~out_valid | out_ready.
  - Latency from an input handshake to that word on out_data is 1 cycle.
- Source readies:
  - Each source ready is asserted only in its own payload state, and is gated by adv.
  - Readies are zero in all other states.
- Payload counter is 22 bits.
- FSM states and transitions:
  - IDLE: counter=0. Source select is fixed priority at packet boundaries only: bbox_valid > logo_valid > img_valid. When adv and a source is valid, emit the header (out_last=0) and go to IMG, BBOX or LOGO. No source is consumed in this cycle.
  - IMG: pass img_data. On the IMG_CNT-th accepted word, assert out_last and return to IDLE. The packet cannot be pre-empted. img_valid gaps only stall.
  - LOGO: same as IMG with LOGO_CNT.
  - BBOX: pass bbox_data and count records.
    - Record number MAX_BBOX accepted: out_last=1. If that record also had bbox_last, go to IDLE; otherwise go to BDROP.
    - bbox_last accepted earlier: that word has out_last=0; go to BPAD.
  - BPAD: emit 64'd0 words with no source handshake, one per adv cycle, until MAX_BBOX payload words in total. out_last=1 on the last one, then IDLE.
  - BDROP: bbox_ready=1 regardless of adv. Discard records, emit nothing, until bbox_last is accepted, then IDLE.
- Boundary conditions:
  - All three sources valid in IDLE: bbox is selected. Image words then wait, with img_ready=0.
  - Single-word bbox result with bbox_last=1 and MAX_BBOX=1: the word carries out_last=1; go directly to IDLE with no padding.
  - Reset mid-packet: state=IDLE, counter=0, out_valid=0, out_last=0, out_data=0, all readies 0 in the following cycle. The partial packet is abandoned; no recovery words are emitted.
  - Reset values: out_valid=0, out_last=0, out_data=0, img_ready=bbox_ready=logo_ready=0.

Optional Feature:
- Macro: DISPLAY_PKT_LOGO_EN.
- Defined: logo source is arbitrated as above.
- Undefined:
  - LOGO state is removed and logo_ready is tied 0.
  - logo_valid is ignored; priority becomes bbox > image.
  - Ports remain present.

Test Plan:
- FRAME_WIDTH=4, FRAME_HEIGHT=2, out_ready=1; 4 image words 0x11..0x44 -> header 0x1, 0x11,0x22,0x33,0x44; out_last only on 0x44. 5 words total, back-to-back.
- MAX_BBOX=4; 2 records A,B, bbox_last on B -> header 0x2, A, B, 0, 0; out_last on the 4th payload word.
- MAX_BBOX=4; 6 records, bbox_last on the 6th -> header 0x2 plus first 4 records, last on record 4. Records 5 and 6 are consumed with no output; next state IDLE.
- img_valid, bbox_valid and logo_valid asserted together in IDLE -> bbox packet first, then logo, then image. img_ready=0 until the image header is emitted.
- Image packet with out_ready toggling 1,0,0,1 -> out_data held constant during the stall; no word duplicated or lost; img_ready low while stalled.
- rst pulsed after 2 image payload words -> following cycle out_valid=0 and state IDLE. Next img_valid produces a fresh header 0x1. Repeat with DISPLAY_PKT_LOGO_EN undefined: logo_valid=1 -> logo_ready stays 0 and no type-3 header ever appears.
